// File: rtl/pool_quant.sv
// pool_quant: reads psum words, optional 2:1 lane-wise max-pool, then ReLU / right-shift / saturate to activations.
// Latency: the activation word is registered and valid the cycle after the psum transfer that completes it.
// Backpressure: POOLGB_rdy drops while the output word is held and not accepted; nothing is overwritten or dropped.
// Build option: define POOL_QUANT_ROUND_EN to add 2^(shift-1) before the shift (round-half-up); default truncates.
module pool_quant #(
  parameter int NUM_PEB    = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ACT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            CFGPOOL_val,
  output logic                            POOLCFG_rdy,
  input  logic [ADDR_WIDTH-1:0]           CFGPOOL_num_addr,
  input  logic [4:0]                      CFGPOOL_shift,
  input  logic                            CFGPOOL_pool_en,
  output logic [ADDR_WIDTH-1:0]           POOLGB_addr,
  output logic                            POOLGB_rdy,
  input  logic                            GBPOOL_val,
  input  logic [PSUM_WIDTH*NUM_PEB-1:0]   GBPOOL_data,
  output logic                            POOLGB_fnh,
  output logic                            POOLACT_val,
  input  logic                            ACTPOOL_rdy,
  output logic [ACT_WIDTH*NUM_PEB-1:0]    POOLACT_data,
  output logic                            POOLACT_last
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FNH} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [ADDR_WIDTH-1:0]          r_num_addr;
  logic [ADDR_WIDTH-1:0]          r_addr;
  logic [4:0]                     r_shift;
  logic                           r_pool_en;
  logic                           r_pool_vld;
  logic [PSUM_WIDTH*NUM_PEB-1:0]  r_pool_dat;
  logic                           r_out_vld;
  logic                           r_out_last;
  logic [ACT_WIDTH*NUM_PEB-1:0]   r_out_dat;
  logic [ACT_WIDTH*NUM_PEB-1:0]   w_act;
  logic                           w_cfg_acc;
  logic                           w_out_free;
  logic                           w_xfer;
  logic                           w_at_last;
  logic                           w_complete;

  // Lane requantiser: negative clamps to zero, so the shift only ever sees non-negative values.
  function automatic logic [ACT_WIDTH-1:0] quant(input logic [PSUM_WIDTH-1:0] v, input logic [4:0] sh);
    logic [PSUM_WIDTH:0] w_ext;
    logic [PSUM_WIDTH:0] w_shf;
    if (v[PSUM_WIDTH-1]) return '0;
    w_ext = {1'b0, v};
`ifdef POOL_QUANT_ROUND_EN
    if (sh != 5'd0) w_ext = w_ext + ((PSUM_WIDTH+1)'(1) << (sh - 5'd1));
`endif
    w_shf = w_ext >> sh;
    if ((w_shf >> ACT_WIDTH) != '0) return '1;
    return w_shf[ACT_WIDTH-1:0];
  endfunction

  assign w_out_free   = !r_out_vld || ACTPOOL_rdy;
  assign w_cfg_acc    = CFGPOOL_val && (r_state == S_IDLE);
  assign w_xfer       = GBPOOL_val && POOLGB_rdy;
  assign w_at_last    = (r_addr == r_num_addr);
  // A word completes an output when not pooling, when it is the second of a pair, or when it is the unpaired tail.
  assign w_complete   = w_xfer && (!r_pool_en || r_pool_vld || w_at_last);
  assign POOLGB_addr  = r_addr;
  assign POOLACT_val  = r_out_vld;
  assign POOLACT_data = r_out_dat;
  assign POOLACT_last = r_out_last;

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    POOLCFG_rdy = 1'b0;
    POOLGB_rdy  = 1'b0;
    POOLGB_fnh  = 1'b0;
    case (r_state)
      S_IDLE: begin
        POOLCFG_rdy = 1'b1;
        if (CFGPOOL_val) w_state_nxt = S_READ;
      end
      S_READ: begin
        POOLGB_rdy = w_out_free;
        if (GBPOOL_val && w_out_free && w_at_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_out_vld) w_state_nxt = S_FNH;
      end
      S_FNH: begin
        POOLGB_fnh  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane-wise max against the held first word of a pair, then requantise.
  always_comb begin
    logic signed [PSUM_WIDTH-1:0] w_new;
    logic signed [PSUM_WIDTH-1:0] w_old;
    logic signed [PSUM_WIDTH-1:0] w_sel;
    w_act = '0;
    w_new = '0;
    w_old = '0;
    w_sel = '0;
    for (int i = 0; i < NUM_PEB; i++) begin
      w_new = GBPOOL_data[i*PSUM_WIDTH +: PSUM_WIDTH];
      w_old = r_pool_dat[i*PSUM_WIDTH +: PSUM_WIDTH];
      w_sel = (r_pool_vld && (w_old > w_new)) ? w_old : w_new;
      w_act[i*ACT_WIDTH +: ACT_WIDTH] = quant(w_sel, r_shift);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Config latch and read address walk; address holds at num_addr after the final transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_addr <= '0;
      r_shift    <= '0;
      r_pool_en  <= 1'b0;
      r_addr     <= '0;
    end else if (w_cfg_acc) begin
      r_num_addr <= CFGPOOL_num_addr;
      r_shift    <= CFGPOOL_shift;
      r_pool_en  <= CFGPOOL_pool_en;
      r_addr     <= '0;
    end else if (w_xfer && !w_at_last) begin
      r_addr     <= r_addr + ADDR_WIDTH'(1);
    end
  end

  // Pool register holds the first word of a pair until its partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pool_vld <= 1'b0;
      r_pool_dat <= '0;
    end else if (w_complete) begin
      r_pool_vld <= 1'b0;
    end else if (w_xfer) begin
      r_pool_vld <= 1'b1;
      r_pool_dat <= GBPOOL_data;
    end
  end

  // Output register: loads on a completing transfer (possibly in the same cycle it is drained).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_dat  <= '0;
    end else if (w_complete) begin
      r_out_vld  <= 1'b1;
      r_out_last <= w_at_last;
      r_out_dat  <= w_act;
    end else if (ACTPOOL_rdy) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end
  end

endmodule
